cam_emulator: RTL

CAM_EMULATOR -- requirements
Module: cam_emulator

---
 rtl/cam_pkg.sv | 43 ++++
 rtl/cam_if.sv | 22 ++
 rtl/cam_pattern_pixel.sv | 42 ++++
 rtl/cam_emulator.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and RGB565 colour constants for the camera emulator.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } cam_state_e;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'b00,
    PAT_BARS  = 2'b01,
    PAT_GREY  = 2'b10,
    PAT_CHECK = 2'b11
  } cam_pattern_e;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_if.sv
// Control inputs and emulated DVP camera outputs of the emulator.
interface cam_if;
  logic       enable_in;
  logic [1:0] pattern_sel_in;
  logic [8:0] box_x_in;
  logic [7:0] box_y_in;
  logic       cam_clk_out;
  logic       vsync_out;
  logic       href_out;
  logic [7:0] pixel_out;
  logic       frame_start_out;

  modport master (
    input  enable_in, pattern_sel_in, box_x_in, box_y_in,
    output cam_clk_out, vsync_out, href_out, pixel_out, frame_start_out
  );

  modport slave (
    output enable_in, pattern_sel_in, box_x_in, box_y_in,
    input  cam_clk_out, vsync_out, href_out, pixel_out, frame_start_out
  );
endinterface

// File: rtl/cam_pattern_pixel.sv
// Combinational test-pattern generator: background selected by pattern,
// overlaid with a solid marker square.
module cam_pattern_pixel
  import cam_pkg::*;
#(
  parameter int          H_ACTIVE  = 320,
  parameter int          BOX_SIZE  = 32,
  parameter logic [15:0] BOX_COLOR = 16'h07E0
) (
  input  logic [8:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [1:0]  pattern_in,
  input  logic [8:0]  box_x_in,
  input  logic [7:0]  box_y_in,
  output logic [15:0] pixel_out
);

  // Narrow frames would give zero-width bars; clamp to one column per bar.
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [9:0]  x10, y10, bx10, by10, bar_idx;
  logic        in_box;
  logic [15:0] bg;

  always_comb begin
    x10     = {1'b0, x_in};
    y10     = {2'b00, y_in};
    bx10    = {1'b0, box_x_in};
    by10    = {2'b00, box_y_in};
    in_box  = (x10 >= bx10) && (x10 < bx10 + 10'(BOX_SIZE)) &&
              (y10 >= by10) && (y10 < by10 + 10'(BOX_SIZE));
    bar_idx = x10 / 10'(BAR_W);
    case (cam_pattern_e'(pattern_in))
      PAT_BARS:  bg = bar_color((bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0]);
      PAT_GREY:  bg = {x_in[8:4], x_in[8:3], x_in[8:4]};
      PAT_CHECK: bg = (x_in[4] ^ y_in[4]) ? RGB_WHITE : RGB_BLACK;
      default:   bg = RGB_BLACK;
    endcase
    pixel_out = in_box ? BOX_COLOR : bg;
  end

endmodule

// File: rtl/cam_emulator.sv
// DVP camera emulator: divides clk_in into PCLK and streams RGB565 frames
// as byte pairs framed by VSYNC/HREF, updating outputs on PCLK falling edges.
module cam_emulator
  import cam_pkg::*;
#(
  parameter int          H_ACTIVE    = 320,
  parameter int          V_ACTIVE    = 240,
  parameter int          H_BLANK     = 144,
  parameter int          VSYNC_LINES = 3,
  parameter int          V_BACK      = 17,
  parameter int          V_FRONT     = 10,
  parameter int          CLK_DIV     = 4,
  parameter int          BOX_SIZE    = 32,
  parameter logic [15:0] BOX_COLOR   = 16'h07E0
) (
  input  logic  clk_in,
  input  logic  rst_in,
  cam_if.master cam
);

  localparam int LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
  localparam int TICK_W     = $clog2(LINE_TICKS);
  localparam int LINE_W     = 10;
  localparam int DIV_W      = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF    = DIV_W'(CLK_DIV / 2);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(LINE_TICKS - 1);
  localparam logic [TICK_W-1:0] HREF_TICKS  = TICK_W'(2 * H_ACTIVE);
  localparam logic [LINE_W-1:0] VSYNC_LAST  = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] VBACK_LAST  = LINE_W'(V_BACK - 1);
  localparam logic [LINE_W-1:0] ACTIVE_LAST = LINE_W'(V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] VFRONT_LAST = LINE_W'(V_FRONT - 1);

  cam_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d, phase_last;
  logic [8:0]        box_x_q, box_x_d;
  logic [7:0]        box_y_q, box_y_d;
  logic [1:0]        pattern_q, pattern_d;
  logic              vsync_q, vsync_d, href_q, href_d, frame_start_q, frame_start_d;
  logic [7:0]        pixel_q, pixel_d;
  logic              tick, enter_vsync;
  logic [8:0]        pix_x;
  logic [7:0]        pix_y;
  logic [15:0]       pix;

  // A tick is the clk_in cycle on which the divider wraps: PCLK falling edge.
  assign tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    line_cnt_d    = line_cnt_q;
    box_x_d       = box_x_q;
    box_y_d       = box_y_q;
    pattern_d     = pattern_q;
    frame_start_d = 1'b0;
    enter_vsync   = 1'b0;
    case (state_q)
      ST_VSYNC:  phase_last = VSYNC_LAST;
      ST_VBACK:  phase_last = VBACK_LAST;
      ST_ACTIVE: phase_last = ACTIVE_LAST;
      default:   phase_last = VFRONT_LAST;
    endcase
    if (tick) begin
      if (state_q == ST_IDLE) begin
        enter_vsync = cam.enable_in;
      end else if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_d = '0;
        if (line_cnt_q == phase_last) begin
          line_cnt_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            ST_VFRONT: begin
              // enable_in is only consulted at frame end, so frames never truncate.
              if (cam.enable_in) enter_vsync = 1'b1;
              else               state_d     = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
          endcase
        end else begin
          line_cnt_d = line_cnt_q + 1'b1;
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
      if (enter_vsync) begin
        state_d       = ST_VSYNC;
        box_x_d       = cam.box_x_in;
        box_y_d       = cam.box_y_in;
        frame_start_d = 1'b1;
      end
      if (tick_cnt_d == '0) pattern_d = cam.pattern_sel_in;
    end
  end

  assign pix_x = 9'(tick_cnt_d >> 1);
  assign pix_y = 8'(line_cnt_d);

  cam_pattern_pixel #(
    .H_ACTIVE  (H_ACTIVE),
    .BOX_SIZE  (BOX_SIZE),
    .BOX_COLOR (BOX_COLOR)
  ) u_pattern (
    .x_in       (pix_x),
    .y_in       (pix_y),
    .pattern_in (pattern_d),
    .box_x_in   (box_x_d),
    .box_y_in   (box_y_d),
    .pixel_out  (pix)
  );

  // Outputs are registered from the position being entered on this tick.
  always_comb begin
    vsync_d = vsync_q;
    href_d  = href_q;
    pixel_d = pixel_q;
    if (tick) begin
      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE) && (tick_cnt_d < HREF_TICKS);
      pixel_d = href_d ? (tick_cnt_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      div_cnt_q     <= '0;
      tick_cnt_q    <= '0;
      line_cnt_q    <= '0;
      box_x_q       <= '0;
      box_y_q       <= '0;
      pattern_q     <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      pixel_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      line_cnt_q    <= line_cnt_d;
      box_x_q       <= box_x_d;
      box_y_q       <= box_y_d;
      pattern_q     <= pattern_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      pixel_q       <= pixel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign cam.cam_clk_out     = (div_cnt_q >= DIV_HALF);
  assign cam.vsync_out       = vsync_q;
  assign cam.href_out        = href_q;
  assign cam.pixel_out       = pixel_q;
  assign cam.frame_start_out = frame_start_q;

endmodule
